mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory port between the instruction-fetch channel and the data (load/store) channel.
//  Sits between the IF / MEM pipeline stages and the single memory interface.
//  Grants one transaction at a time and registers the request towards memory.
//  Routes the read response back to the requester that owns the transaction.
//  Data has priority; a starvation counter guarantees that fetch eventually wins.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive data grants while a fetch waits before the fetch is forced (0 = strict data priority)
//  CNT_W         3   width of the starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  inst_req_addr    in   32  fetch address
//  inst_req_valid   in   1   fetch request valid
//  inst_req_ready   out  1   fetch request accepted
//  inst_rdata       out  32  fetched word
//  inst_resp_valid  out  1   fetch response valid
//  inst_resp_ready  in   1   IF can take the response
//  data_req_addr    in   32  load/store address
//  data_req_wen     in   1   1 = store, 0 = load
//  data_req_wdata   in   32  store data
//  data_req_wstrb   in   4   store byte strobes
//  data_req_valid   in   1   data request valid
//  data_req_ready   out  1   data request accepted
//  data_rdata       out  32  load data
//  data_resp_valid  out  1   load response valid
//  data_resp_ready  in   1   MEM can take the response
//  mem_addr         out  32  registered address to memory
//  mem_wen          out  1   registered write enable
//  mem_wdata        out  32  registered write data
//  mem_wstrb        out  4   registered strobes
//  mem_req_valid    out  1   request to memory valid
//  mem_req_ready    in   1   memory accepts the request
//  mem_rdata        in   32  memory read data
//  mem_resp_valid   in   1   memory read response valid
//  mem_resp_ready   out  1   arbiter (owner) accepts the response
//  arb_busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset:
//    - state = IDLE; owner = DATA; starve_cnt = 0.
//    - mem_addr, mem_wdata, mem_wstrb = 0; mem_wen = 0.
//    - All valid/ready outputs are 0 during rst and in the first cycle after it.
//    - rst mid-transaction abandons the transaction; the memory is reset together with the arbiter.
//  - FSM, one-hot:
//    - IDLE -> REQ when a grant is made.
//    - REQ -> IDLE on mem_req_valid && mem_req_ready for a store.
//    - REQ -> RESP on the same handshake for a load or a fetch.
//    - RESP -> IDLE on mem_resp_valid && mem_resp_ready.
//  - Grant (IDLE only, combinational):
//    - Fetch is granted when inst_req_valid && (!data_req_valid || (STARVE_LIMIT != 0 && starve_cnt == STARVE_LIMIT)).
//    - Otherwise data is granted when data_req_valid.
//    - The winner's *_req_ready = 1 in that same cycle; the loser sees 0.
//    - Both *_req_ready are 0 outside IDLE.
//  - Capture on grant:
//    - addr, wen, wdata and wstrb are latched into the mem_* registers.
//    - For a fetch, wen = 0 and wstrb = 0.
//    - owner is latched.
//  - Timing:
//    - mem_req_valid = (state == REQ), so it rises 1 cycle after the requester handshake.
//    - mem_req_valid stays high, with mem_* stable, until mem_req_ready.
//  - RESP routing, combinational:
//    - owner_resp_valid = mem_resp_valid; the non-owner resp_valid = 0.
//    - mem_resp_ready = owner_resp_ready.
//    - inst_rdata and data_rdata both carry mem_rdata; only the valid is steered.
//  - Starvation counter, updated on a grant:
//    - Data grant with inst_req_valid = 1: starve_cnt++, saturating at STARVE_LIMIT.
//    - Fetch grant: starve_cnt cleared.
//    - Data grant with inst_req_valid = 0: starve_cnt cleared.
//  - Stores produce no response and never touch *_resp_valid.
//  - Back-to-back rate: one grant at most every 2 cycles (IDLE, REQ) for stores and 3+ cycles for reads.
//  - A requester dropping valid before its grant is legal; no grant is made and no state changes.
// TESTING
//  - Reset: hold rst 3 cycles with both requesters valid -> no ready/valid asserted; IDLE 1 cycle after rst falls.
//  - Single fetch, addr 0x100, mem ready and 2-cycle response 0xDEADBEEF:
//    - inst_req_ready at t, mem_req_valid at t+1.
//    - inst_resp_valid with rdata 0xDEADBEEF; data_resp_valid stays 0.
//  - Simultaneous fetch + load: data granted first; the fetch is granted right after the load response completes.
//  - Starvation, STARVE_LIMIT = 4, data and fetch valid continuously: 4 data grants, then 1 fetch, then data again.
//  - Store, wstrb 4'b0011, mem_req_ready held low 5 cycles:
//    - mem_* stay stable.
//    - Returns to IDLE after the handshake with no response expected.
//  - Response backpressure: data_resp_ready = 0 for 3 cycles -> mem_resp_ready = 0; the arbiter stays in RESP.
//  - Mid-RESP rst -> all valids drop; the next fetch is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory port between the fetch channel and the load/store channel.
// Latency: grant in the requester's cycle, mem_req_valid one cycle later, response passes through combinationally.
// Backpressure: mem_* held stable until mem_req_ready; response ready/valid steered straight to the owner.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch channel
    input  logic [31:0] inst_req_addr,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    output logic [31:0] inst_rdata,
    output logic        inst_resp_valid,
    input  logic        inst_resp_ready,
    // data (load/store) channel
    input  logic [31:0] data_req_addr,
    input  logic        data_req_wen,
    input  logic [31:0] data_req_wdata,
    input  logic [3:0]  data_req_wstrb,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    output logic [31:0] data_rdata,
    output logic        data_resp_valid,
    input  logic        data_resp_ready,
    // memory port
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    output logic        arb_busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RESP = 3'b100
    } state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_t;

    localparam bit             STARVE_EN = (STARVE_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    // Low for the first cycle after reset so no handshake can complete in it.
    logic             live;

    logic             can_grant;
    logic             starve_hit;
    logic             grant_inst;
    logic             grant_data;
    logic             in_resp;
    logic             owner_resp_ready;

    // Grant decision: data wins unless no data is pending or the fetch has waited long enough.
    always_comb begin
        starve_hit = STARVE_EN && (starve_cnt == LIMIT_C);
        can_grant  = (state == ST_IDLE) && live && !rst;
        grant_inst = can_grant && inst_req_valid && (!data_req_valid || starve_hit);
        grant_data = can_grant && data_req_valid && !grant_inst;
    end

    // Response steering: only the owner of the outstanding read sees the valid.
    always_comb begin
        in_resp          = (state == ST_RESP) && !rst;
        owner_resp_ready = (owner == OWN_INST) ? inst_resp_ready : data_resp_ready;
        mem_resp_ready   = in_resp && owner_resp_ready;
        inst_resp_valid  = in_resp && (owner == OWN_INST) && mem_resp_valid;
        data_resp_valid  = in_resp && (owner == OWN_DATA) && mem_resp_valid;
        inst_rdata       = mem_rdata;
        data_rdata       = mem_rdata;
        inst_req_ready   = grant_inst;
        data_req_ready   = grant_data;
        mem_req_valid    = (state == ST_REQ) && !rst;
        arb_busy         = (state != ST_IDLE);
    end

    // Transaction FSM with request capture and starvation tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_DATA;
            starve_cnt <= '0;
            live       <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_inst) begin
                        mem_addr   <= inst_req_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                        owner      <= OWN_INST;
                        starve_cnt <= '0;
                        state      <= ST_REQ;
                    end else if (grant_data) begin
                        mem_addr  <= data_req_addr;
                        mem_wen   <= data_req_wen;
                        mem_wdata <= data_req_wdata;
                        mem_wstrb <= data_req_wstrb;
                        owner     <= OWN_DATA;
                        if (!inst_req_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != LIMIT_C) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        // Stores complete on the request handshake; reads wait for data.
                        state <= (owner == OWN_DATA && mem_wen) ? ST_IDLE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid && owner_resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed checks of arbitration, capture, response steering and reset for mem_bus_arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: memory ready/response driven directly by the stimulus sequence.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] inst_req_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_resp_valid;
    logic        inst_resp_ready;
    logic [31:0] data_req_addr;
    logic        data_req_wen;
    logic [31:0] data_req_wdata;
    logic [3:0]  data_req_wstrb;
    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_rdata;
    logic        data_resp_valid;
    logic        data_resp_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic        arb_busy;

    int vectors;
    int miscompares;
    logic exp_inst;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_addr   (inst_req_addr),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_rdata      (inst_rdata),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_ready (inst_resp_ready),
        .data_req_addr   (data_req_addr),
        .data_req_wen    (data_req_wen),
        .data_req_wdata  (data_req_wdata),
        .data_req_wstrb  (data_req_wstrb),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_rdata      (data_rdata),
        .data_resp_valid (data_resp_valid),
        .data_resp_ready (data_resp_ready),
        .mem_addr        (mem_addr),
        .mem_wen         (mem_wen),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_rdata       (mem_rdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_ready  (mem_resp_ready),
        .arb_busy        (arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        inst_req_addr   = 32'h0;
        inst_req_valid  = 1'b1;
        inst_resp_ready = 1'b1;
        data_req_addr   = 32'h0;
        data_req_wen    = 1'b0;
        data_req_wdata  = 32'h0;
        data_req_wstrb  = 4'h0;
        data_req_valid  = 1'b1;
        data_resp_ready = 1'b1;
        mem_req_ready   = 1'b0;
        mem_rdata       = 32'h0;
        mem_resp_valid  = 1'b0;

        // Reset held 3 cycles with both requesters asserting.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_inst_rdy", inst_req_ready, 0);
            chk("rst_data_rdy", data_req_ready, 0);
            chk("rst_mem_vld", mem_req_valid, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_inst_rdy", inst_req_ready, 0);
        chk("post_rst_data_rdy", data_req_ready, 0);
        chk("post_rst_busy", arb_busy, 0);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wen", mem_wen, 0);
        chk("post_rst_wstrb", mem_wstrb, 0);
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        cyc();

        // Single fetch with a two-cycle response.
        inst_req_valid = 1'b1;
        inst_req_addr  = 32'h100;
        #1;
        chk("f_inst_rdy", inst_req_ready, 1);
        chk("f_data_rdy", data_req_ready, 0);
        chk("f_mem_vld_t", mem_req_valid, 0);
        cyc();
        inst_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        chk("f_mem_vld_t1", mem_req_valid, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_wen", mem_wen, 0);
        chk("f_busy", arb_busy, 1);
        cyc();
        mem_req_ready = 1'b0;
        #1;
        chk("f_mem_vld_drop", mem_req_valid, 0);
        chk("f_resp_early", inst_resp_valid, 0);
        cyc();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEADBEEF;
        #1;
        chk("f_inst_resp_vld", inst_resp_valid, 1);
        chk("f_inst_rdata", inst_rdata, 32'hDEADBEEF);
        chk("f_data_resp_vld", data_resp_valid, 0);
        chk("f_mem_resp_rdy", mem_resp_ready, 1);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("f_idle", arb_busy, 0);

        // Simultaneous fetch and load: load first, fetch straight after.
        inst_req_valid = 1'b1;
        inst_req_addr  = 32'h104;
        data_req_valid = 1'b1;
        data_req_addr  = 32'h200;
        data_req_wen   = 1'b0;
        #1;
        chk("fl_data_rdy", data_req_ready, 1);
        chk("fl_inst_rdy", inst_req_ready, 0);
        cyc();
        data_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        chk("fl_mem_addr", mem_addr, 32'h200);
        chk("fl_inst_rdy_req", inst_req_ready, 0);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h12345678;
        #1;
        chk("fl_data_resp_vld", data_resp_valid, 1);
        chk("fl_inst_resp_vld", inst_resp_valid, 0);
        chk("fl_data_rdata", data_rdata, 32'h12345678);
        chk("fl_inst_rdy_resp", inst_req_ready, 0);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("fl_fetch_next", inst_req_ready, 1);
        cyc();
        inst_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        chk("fl_fetch_addr", mem_addr, 32'h104);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        cyc();
        mem_resp_valid = 1'b0;

        // Starvation: continuous stores plus a waiting fetch -> D,D,D,D,I,D.
        inst_req_valid = 1'b1;
        inst_req_addr  = 32'h180;
        data_req_valid = 1'b1;
        data_req_wen   = 1'b1;
        data_req_addr  = 32'h280;
        data_req_wdata = 32'h55AA55AA;
        data_req_wstrb = 4'hF;
        mem_req_ready  = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_inst = (g == 4);
            #1;
            chk("starve_inst_rdy", inst_req_ready, exp_inst);
            chk("starve_data_rdy", data_req_ready, !exp_inst);
            cyc();
            cyc();
            if (exp_inst) begin
                mem_resp_valid = 1'b1;
                cyc();
                mem_resp_valid = 1'b0;
            end
        end
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        mem_req_ready  = 1'b0;
        #1;
        chk("starve_end_idle", arb_busy, 0);

        // Store held off by memory for 5 cycles.
        data_req_valid = 1'b1;
        data_req_wen   = 1'b1;
        data_req_addr  = 32'h300;
        data_req_wdata = 32'hCAFEF00D;
        data_req_wstrb = 4'b0011;
        #1;
        chk("st_data_rdy", data_req_ready, 1);
        cyc();
        data_req_valid = 1'b0;
        data_req_addr  = 32'hFFFF;
        data_req_wdata = 32'h0;
        data_req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_mem_vld", mem_req_valid, 1);
            chk("st_mem_addr", mem_addr, 32'h300);
            chk("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
            chk("st_mem_wstrb", mem_wstrb, 4'b0011);
            chk("st_mem_wen", mem_wen, 1);
            cyc();
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        #1;
        chk("st_idle", arb_busy, 0);
        chk("st_no_resp", data_resp_valid, 0);
        chk("st_mem_vld_drop", mem_req_valid, 0);

        // Load response backpressured for 3 cycles.
        data_req_valid = 1'b1;
        data_req_wen   = 1'b0;
        data_req_addr  = 32'h400;
        #1;
        chk("bp_data_rdy", data_req_ready, 1);
        cyc();
        data_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        cyc();
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b1;
        mem_rdata       = 32'hA5A5A5A5;
        data_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_mem_resp_rdy", mem_resp_ready, 0);
            chk("bp_data_resp_vld", data_resp_valid, 1);
            chk("bp_busy", arb_busy, 1);
            cyc();
        end
        data_resp_ready = 1'b1;
        #1;
        chk("bp_mem_resp_rdy_1", mem_resp_ready, 1);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("bp_idle", arb_busy, 0);

        // Reset while a fetch response is pending, then a normal fetch.
        inst_req_valid = 1'b1;
        inst_req_addr  = 32'h500;
        #1;
        chk("mr_inst_rdy", inst_req_ready, 1);
        cyc();
        inst_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        cyc();
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b1;
        inst_resp_ready = 1'b0;
        #1;
        chk("mr_resp_vld_pre", inst_resp_valid, 1);
        rst = 1'b1;
        #1;
        chk("mr_resp_vld_rst", inst_resp_valid, 0);
        chk("mr_mem_resp_rdy_rst", mem_resp_ready, 0);
        cyc();
        chk("mr_busy_rst", arb_busy, 0);
        rst             = 1'b0;
        mem_resp_valid  = 1'b0;
        inst_resp_ready = 1'b1;
        inst_req_valid  = 1'b1;
        inst_req_addr   = 32'h600;
        #1;
        chk("mr_first_cycle_rdy", inst_req_ready, 0);
        cyc();
        chk("mr_inst_rdy_again", inst_req_ready, 1);
        cyc();
        inst_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        chk("mr_mem_addr", mem_addr, 32'h600);
        chk("mr_mem_vld", mem_req_valid, 1);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0BADCAFE;
        #1;
        chk("mr_inst_resp_vld", inst_resp_valid, 1);
        chk("mr_inst_rdata", inst_rdata, 32'h0BADCAFE);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("mr_idle", arb_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
